// File: rtl/prog_fetch_queue_if.sv
// Fetch-side bundle for the program prefetch queue: redirect, consumer handshake
// and the program ROM read port. 'slave' is the queue, 'master' is core plus ROM.
interface prog_fetch_queue_if #(
  parameter int PC_WIDTH = 14
);
  logic                pc_load;
  logic [PC_WIDTH-1:0] pc_new;
  logic                instr_ack;
  logic                rom_en;
  logic [PC_WIDTH-1:0] rom_addr;
  logic [15:0]         rom_rdata;
  logic                instr_valid;
  logic [15:0]         instruction;
  logic [15:0]         instr_ext;
  logic                instr_long;
  logic [PC_WIDTH-1:0] program_counter;

  modport master (
    output pc_load, pc_new, instr_ack, rom_rdata,
    input  rom_en, rom_addr, instr_valid, instruction, instr_ext, instr_long,
           program_counter
  );

  modport slave (
    input  pc_load, pc_new, instr_ack, rom_rdata,
    output rom_en, rom_addr, instr_valid, instruction, instr_ext, instr_long,
           program_counter
  );
endinterface

// File: rtl/prog_fetch_queue.sv
// Instruction prefetch queue: keeps up to DEPTH program words ahead of the consumer
// and presents one 16- or 32-bit instruction at a time, with flush on redirect.
module prog_fetch_queue #(
  parameter int PC_WIDTH = 14,
  parameter int DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  prog_fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0]       ptr_t;
  typedef logic [CW-1:0]       cnt_t;
  typedef logic [CW:0]         occ_t;
  typedef logic [PC_WIDTH-1:0] pc_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // LDS/STS and JMP/CALL carry a second operand word.
  function automatic logic is_long(input logic [15:0] w);
    return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
  endfunction

  logic [15:0] mem_q [DEPTH];
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  cnt_t        count_q, count_d;
  logic        inflight_q, inflight_d;
  pc_t         fpc_q, fpc_d;
  pc_t         pc_q, pc_d;

  logic [15:0] head_w;
  logic [15:0] next_w;
  logic        head_long;
  logic        valid;
  logic        fetch_en;
  logic        push;
  logic        pop;
  logic [1:0]  pop_len;
  occ_t        occupancy;

  always_comb begin
    head_w    = mem_q[rd_ptr_q];
    next_w    = mem_q[ptr_inc(rd_ptr_q)];
    head_long = is_long(head_w);
    valid     = head_long ? (count_q >= cnt_t'(2)) : (count_q != '0);
    // The in-flight word already owns a slot, so it counts against capacity.
    occupancy = occ_t'(count_q) + occ_t'(inflight_q);
    fetch_en  = !reset && !bus.pc_load && (occupancy < occ_t'(DEPTH));
    push      = inflight_q && !bus.pc_load;
    pop       = valid && bus.instr_ack && !bus.pc_load;
    pop_len   = head_long ? 2'd2 : 2'd1;
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fpc_d      = fpc_q;
    pc_d       = pc_q;
    inflight_d = fetch_en;
    if (bus.pc_load) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      fpc_d    = bus.pc_new;
      pc_d     = bus.pc_new;
    end else begin
      if (fetch_en) fpc_d = fpc_q + pc_t'(1);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_d = head_long ? ptr_inc(ptr_inc(rd_ptr_q)) : ptr_inc(rd_ptr_q);
        pc_d     = pc_q + pc_t'(pop_len);
      end
      count_d = count_q + cnt_t'(push) - (pop ? cnt_t'(pop_len) : cnt_t'(0));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      fpc_q      <= '0;
      pc_q       <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      fpc_q      <= fpc_d;
      pc_q       <= pc_d;
    end
  end

  // Word storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.rom_rdata;
  end

  assign bus.rom_en          = fetch_en;
  assign bus.rom_addr        = fpc_q;
  assign bus.instr_valid     = valid;
  assign bus.instruction     = valid ? head_w : 16'h0000;
  assign bus.instr_ext       = (valid && head_long) ? next_w : 16'h0000;
  assign bus.instr_long      = valid && head_long;
  assign bus.program_counter = pc_q;
endmodule

// File: tb/tb_prog_fetch_queue.sv
// Bench for prog_fetch_queue: directed scenarios plus randomized traffic checked
// against an address-level model of the fetch stream.
module tb_prog_fetch_queue;
  localparam int PCW   = 14;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic reset2;
  int   tests_run = 0;
  int   fails     = 0;

  prog_fetch_queue_if #(.PC_WIDTH(PCW)) bus ();
  prog_fetch_queue_if #(.PC_WIDTH(PCW)) bus2 ();

  prog_fetch_queue #(.PC_WIDTH(PCW), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  prog_fetch_queue #(.PC_WIDTH(PCW), .DEPTH(2)) dut2 (.clk(clk), .reset(reset2), .bus(bus2));

  logic [15:0] rom [0:(1<<PCW)-1];

  always @(posedge clk) begin
    bus.rom_rdata  <= bus.rom_en  ? rom[bus.rom_addr]  : 16'($urandom);
    bus2.rom_rdata <= bus2.rom_en ? rom[bus2.rom_addr] : 16'($urandom);
  end

  function automatic logic long_word(input logic [15:0] w);
    return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
  endfunction

  // Model in terms of addresses: pc = presented, fpc = next to fetch,
  // arr = first address whose data has not yet arrived.
  logic [PCW-1:0] m_pc, m_fpc, m_arr, m_avail, m_outst;
  logic           m_en_prev, m_long, m_valid, m_rom_en, e_long;
  logic [15:0]    m_head, m_next, e_instr, e_ext;

  always_comb begin
    m_outst  = m_fpc - m_pc;
    m_avail  = m_arr - m_pc;
    m_head   = rom[m_pc];
    m_next   = rom[m_pc + PCW'(1)];
    m_long   = long_word(m_head);
    m_valid  = !reset && (m_avail >= (m_long ? PCW'(2) : PCW'(1)));
    m_rom_en = !reset && !bus.pc_load && (m_outst < PCW'(DEPTH));
    e_instr  = m_valid ? m_head : 16'h0000;
    e_long   = m_valid && m_long;
    e_ext    = e_long ? m_next : 16'h0000;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= '0; m_fpc <= '0; m_arr <= '0; m_en_prev <= 1'b0;
    end else if (bus.pc_load) begin
      m_pc <= bus.pc_new; m_fpc <= bus.pc_new; m_arr <= bus.pc_new; m_en_prev <= 1'b0;
    end else begin
      if (m_en_prev) m_arr <= m_arr + PCW'(1);
      if (m_rom_en) m_fpc <= m_fpc + PCW'(1);
      m_en_prev <= m_rom_en;
      if (bus.instr_ack && m_valid) m_pc <= m_pc + (m_long ? PCW'(2) : PCW'(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int a = 0; a < (1 << PCW); a++) rom[a] = 16'($urandom);
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    tests_run++;
    if ({bus.rom_en, bus.rom_addr, bus.instr_valid, bus.instruction, bus.instr_ext,
         bus.instr_long, bus.program_counter} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got en=%0b addr=%h v=%0b pc=%h, expected all zero",
               bus.rom_en, bus.rom_addr, bus.instr_valid, bus.program_counter);
    end
    tick();
    reset = 1'b0;
    bus.instr_ack = 1'b1;
    #1;
    tests_run++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== '0) begin
      fails++;
      $display("FAIL first_fetch: got en=%0b addr=%h, expected en=1 addr=0000", bus.rom_en, bus.rom_addr);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus.instr_valid !== m_valid || bus.program_counter !== m_pc || bus.instruction !== e_instr ||
          bus.instr_ext !== e_ext || bus.instr_long !== e_long || bus.rom_en !== m_rom_en ||
          (m_rom_en && bus.rom_addr !== m_fpc)) begin
        fails++;
        $display("FAIL reset_run: got v=%0b pc=%h ins=%h en=%0b ad=%h, expected v=%0b pc=%h ins=%h en=%0b ad=%h",
                 bus.instr_valid, bus.program_counter, bus.instruction, bus.rom_en, bus.rom_addr,
                 m_valid, m_pc, e_instr, m_rom_en, m_fpc);
      end
      tick();
    end
    // Pulse reset while a read is outstanding; its response must be dropped.
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.rom_en, bus.instr_valid, bus.instruction, bus.instr_ext, bus.instr_long,
         bus.program_counter} !== '0) begin
      fails++;
      $display("FAIL async_reset: got en=%0b v=%0b pc=%h, expected all zero",
               bus.rom_en, bus.instr_valid, bus.program_counter);
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus.instr_valid !== m_valid || bus.program_counter !== m_pc || bus.instruction !== e_instr ||
          bus.instr_ext !== e_ext || bus.instr_long !== e_long || bus.rom_en !== m_rom_en ||
          (m_rom_en && bus.rom_addr !== m_fpc)) begin
        fails++;
        $display("FAIL stale_drop: got v=%0b pc=%h ins=%h en=%0b ad=%h, expected v=%0b pc=%h ins=%h en=%0b ad=%h",
                 bus.instr_valid, bus.program_counter, bus.instruction, bus.rom_en, bus.rom_addr,
                 m_valid, m_pc, e_instr, m_rom_en, m_fpc);
      end
      tick();
    end
    bus.instr_ack = 1'b0;
  endtask

  task automatic test_prime();
    for (int a = 0; a < 16; a++) rom[a] = 16'h0000;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.rom_en !== 1'b1 || bus.rom_addr !== PCW'(i)) begin
        fails++;
        $display("FAIL prime_addr: got en=%0b addr=%h, expected en=1 addr=%h", bus.rom_en, bus.rom_addr, PCW'(i));
      end
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus.rom_en !== 1'b0) begin
        fails++;
        $display("FAIL prime_full: got en=%0b, expected en=0", bus.rom_en);
      end
      tick();
    end
    @(negedge clk);
    tests_run++;
    if (bus.instr_valid !== 1'b1 || bus.program_counter !== '0 || bus.instruction !== 16'h0000 ||
        bus.instr_long !== 1'b0) begin
      fails++;
      $display("FAIL prime_present: got v=%0b pc=%h lg=%0b, expected v=1 pc=0000 lg=0",
               bus.instr_valid, bus.program_counter, bus.instr_long);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [PCW-1:0] prev;
    for (int a = 0; a < 100; a++) rom[14'h0400 + a] = 16'($urandom) & 16'h7FFF;
    bus.pc_load = 1'b1; bus.pc_new = 14'h0400; bus.instr_ack = 1'b1;
    tick();
    bus.pc_load = 1'b0;
    prev = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus.instr_valid !== m_valid || bus.program_counter !== m_pc || bus.instruction !== e_instr ||
          bus.instr_ext !== e_ext || bus.instr_long !== e_long || bus.rom_en !== m_rom_en ||
          (m_rom_en && bus.rom_addr !== m_fpc)) begin
        fails++;
        $display("FAIL stream_model: got v=%0b pc=%h ins=%h en=%0b ad=%h, expected v=%0b pc=%h ins=%h en=%0b ad=%h",
                 bus.instr_valid, bus.program_counter, bus.instruction, bus.rom_en, bus.rom_addr,
                 m_valid, m_pc, e_instr, m_rom_en, m_fpc);
      end
      if (c >= 4) begin
        tests_run++;
        if (bus.instr_valid !== 1'b1 || bus.program_counter !== prev + PCW'(1)) begin
          fails++;
          $display("FAIL stream_rate: got v=%0b pc=%h, expected v=1 pc=%h",
                   bus.instr_valid, bus.program_counter, prev + PCW'(1));
        end
      end
      prev = bus.program_counter;
      tick();
    end
    bus.instr_ack = 1'b0;
    tick();
  endtask

  task automatic test_long();
    logic [PCW-1:0] a;
    logic [15:0]    w0, w1;
    logic           lg;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin a = 14'h0005; w0 = 16'h940C; w1 = 16'h0123; lg = 1'b1; end
        1:       begin a = 14'h0100; w0 = 16'h91F0; w1 = 16'hBEEF; lg = 1'b1; end
        default: begin a = 14'h0180; w0 = 16'h940B; w1 = 16'h7777; lg = 1'b0; end
      endcase
      rom[a] = w0; rom[a + PCW'(1)] = w1;
      for (int j = 2; j < 8; j++) rom[a + PCW'(j)] = 16'h0000;
      bus.pc_load = 1'b1; bus.pc_new = a; bus.instr_ack = 1'b0;
      tick();
      bus.pc_load = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (bus.instr_valid) break;
        tick();
      end
      @(negedge clk);
      tests_run++;
      if (bus.instr_valid !== 1'b1 || bus.instr_long !== lg || bus.instruction !== w0 ||
          bus.instr_ext !== (lg ? w1 : 16'h0000) || bus.program_counter !== a) begin
        fails++;
        $display("FAIL long_present: got v=%0b lg=%0b ins=%h ext=%h pc=%h, expected v=1 lg=%0b ins=%h ext=%h pc=%h",
                 bus.instr_valid, bus.instr_long, bus.instruction, bus.instr_ext, bus.program_counter,
                 lg, w0, lg ? w1 : 16'h0000, a);
      end
      tick();
      bus.instr_ack = 1'b1;
      tick();
      bus.instr_ack = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.program_counter !== a + (lg ? PCW'(2) : PCW'(1))) begin
        fails++;
        $display("FAIL long_advance: got pc=%h, expected pc=%h", bus.program_counter, a + (lg ? PCW'(2) : PCW'(1)));
      end
      tick();
    end
  endtask

  task automatic test_underflow();
    rom[14'h0040] = 16'h940C; rom[14'h0041] = 16'h0055;
    for (int j = 2; j < 6; j++) rom[14'h0040 + j] = 16'h0000;
    bus2.pc_load = 1'b1; bus2.pc_new = 14'h0040; bus2.instr_ack = 1'b0;
    reset2 = 1'b0;
    tick();
    bus2.pc_load = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus2.rom_en !== 1'b1 || bus2.rom_addr !== 14'h0040) begin
      fails++;
      $display("FAIL uf_fetch: got en=%0b addr=%h, expected en=1 addr=0040", bus2.rom_en, bus2.rom_addr);
    end
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if (bus2.instr_valid !== 1'b0 || bus2.rom_en !== 1'b0) begin
      fails++;
      $display("FAIL uf_half: got v=%0b en=%0b, expected v=0 en=0", bus2.instr_valid, bus2.rom_en);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus2.instr_valid !== 1'b1 || bus2.instr_long !== 1'b1 || bus2.instruction !== 16'h940C ||
        bus2.instr_ext !== 16'h0055 || bus2.program_counter !== 14'h0040) begin
      fails++;
      $display("FAIL uf_full: got v=%0b lg=%0b ins=%h ext=%h pc=%h, expected v=1 lg=1 ins=940c ext=0055 pc=0040",
               bus2.instr_valid, bus2.instr_long, bus2.instruction, bus2.instr_ext, bus2.program_counter);
    end
    tick();
    bus2.instr_ack = 1'b1;
    tick();
    bus2.instr_ack = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus2.program_counter !== 14'h0042) begin
      fails++;
      $display("FAIL uf_advance: got pc=%h, expected pc=0042", bus2.program_counter);
    end
    tick();
    reset2 = 1'b1;
  endtask

  task automatic test_redirect();
    for (int a = 0; a < 32; a++) begin
      rom[14'h0080 + a] = 16'($urandom) & 16'h7FFF;
      rom[14'h0200 + a] = 16'($urandom) & 16'h7FFF;
    end
    bus.pc_load = 1'b1; bus.pc_new = 14'h0080; bus.instr_ack = 1'b1;
    tick();
    bus.pc_load = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    bus.pc_load = 1'b1; bus.pc_new = 14'h0200;
    @(negedge clk);
    tests_run++;
    if (bus.rom_en !== 1'b0) begin
      fails++;
      $display("FAIL redir_hold: got en=%0b, expected en=0", bus.rom_en);
    end
    tick();
    bus.pc_load = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== 14'h0200 || bus.instr_valid !== 1'b0 ||
        bus.program_counter !== 14'h0200) begin
      fails++;
      $display("FAIL redir_fetch: got en=%0b addr=%h v=%0b pc=%h, expected en=1 addr=0200 v=0 pc=0200",
               bus.rom_en, bus.rom_addr, bus.instr_valid, bus.program_counter);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL redir_gap: got v=%0b, expected v=0", bus.instr_valid);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.instr_valid !== 1'b1 || bus.program_counter !== 14'h0200 || bus.instruction !== rom[14'h0200]) begin
      fails++;
      $display("FAIL redir_valid: got v=%0b pc=%h ins=%h, expected v=1 pc=0200 ins=%h",
               bus.instr_valid, bus.program_counter, bus.instruction, rom[14'h0200]);
    end
    bus.instr_ack = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    rom[14'h3FFF] = 16'($urandom) & 16'h7FFF;
    for (int a = 0; a < 8; a++) rom[a] = 16'($urandom) & 16'h7FFF;
    bus.pc_load = 1'b1; bus.pc_new = 14'h3FFF; bus.instr_ack = 1'b0;
    tick();
    bus.pc_load = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== 14'h3FFF) begin
      fails++;
      $display("FAIL wrap_fetch0: got en=%0b addr=%h, expected en=1 addr=3fff", bus.rom_en, bus.rom_addr);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.rom_en !== 1'b1 || bus.rom_addr !== 14'h0000) begin
      fails++;
      $display("FAIL wrap_fetch1: got en=%0b addr=%h, expected en=1 addr=0000", bus.rom_en, bus.rom_addr);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if (bus.instr_valid !== 1'b1 || bus.program_counter !== 14'h3FFF) begin
      fails++;
      $display("FAIL wrap_present: got v=%0b pc=%h, expected v=1 pc=3fff", bus.instr_valid, bus.program_counter);
    end
    tick();
    bus.instr_ack = 1'b1;
    tick();
    bus.instr_ack = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.program_counter !== 14'h0000 || bus.instr_valid !== 1'b1 || bus.instruction !== rom[0]) begin
      fails++;
      $display("FAIL wrap_pc: got pc=%h v=%0b ins=%h, expected pc=0000 v=1 ins=%h",
               bus.program_counter, bus.instr_valid, bus.instruction, rom[0]);
    end
    tick();
  endtask

  task automatic test_random();
    for (int a = 0; a < (1 << PCW); a++)
      rom[a] = ($urandom_range(0, 7) == 0) ? (16'h940C | (16'($urandom) & 16'h01F3)) : 16'($urandom);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.pc_load   = ($urandom_range(0, 31) == 0);
      bus.pc_new    = PCW'($urandom);
      bus.instr_ack = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      tests_run++;
      if (bus.instr_valid !== m_valid || bus.program_counter !== m_pc || bus.instruction !== e_instr ||
          bus.instr_ext !== e_ext || bus.instr_long !== e_long || bus.rom_en !== m_rom_en ||
          (m_rom_en && bus.rom_addr !== m_fpc)) begin
        fails++;
        $display("FAIL random_model: got v=%0b pc=%h ins=%h ext=%h lg=%0b en=%0b ad=%h, expected v=%0b pc=%h ins=%h ext=%h lg=%0b en=%0b ad=%h",
                 bus.instr_valid, bus.program_counter, bus.instruction, bus.instr_ext, bus.instr_long,
                 bus.rom_en, bus.rom_addr, m_valid, m_pc, e_instr, e_ext, e_long, m_rom_en, m_fpc);
      end
      tick();
    end
    bus.pc_load = 1'b0;
    bus.instr_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    bus.pc_load = 1'b0;  bus.pc_new = '0;  bus.instr_ack = 1'b0;
    bus2.pc_load = 1'b0; bus2.pc_new = '0; bus2.instr_ack = 1'b0;
    tick();
    test_reset();
    test_prime();
    test_stream();
    test_long();
    test_underflow();
    test_redirect();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/prog_fetch_queue.md
PROG_FETCH_QUEUE -- requirements
Module: prog_fetch_queue

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 14, giving the program word-address width.
REQ-002 SHALL have parameter DEPTH, default 4, giving the prefetch queue depth in 16-bit words; legal values are 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port pc_load, input, 1 bit: flush the queue and redirect fetch (branch, jump, interrupt).
REQ-006 SHALL have port pc_new, input, PC_WIDTH bits: the redirect target word address.
REQ-007 SHALL have port instr_ack, input, 1 bit: the consumer retires the presented instruction.
REQ-008 SHALL have port rom_en, output, 1 bit: program ROM read request.
REQ-009 SHALL have port rom_addr, output, PC_WIDTH bits: program ROM word address.
REQ-010 SHALL have port rom_rdata, input, 16 bits: ROM data, valid exactly one cycle after rom_en.
REQ-011 SHALL have port instr_valid, output, 1 bit: a complete instruction is presented.
REQ-012 SHALL have port instruction, output, 16 bits: the first word of the presented instruction.
REQ-013 SHALL have port instr_ext, output, 16 bits: the second word for 32-bit instructions, else 0.
REQ-014 SHALL have port instr_long, output, 1 bit: the presented instruction is 32-bit.
REQ-015 SHALL have port program_counter, output, PC_WIDTH bits: word address of the presented instruction.

Function
REQ-016 SHALL hold a FIFO of up to DEPTH words, a fetch pointer fpc, an in-flight flag and the program_counter register.
REQ-017 SHALL assert rom_en with rom_addr=fpc in any cycle where count+inflight<DEPTH, pc_load=0 and the design is not in reset; fpc then increments at that edge.
REQ-018 SHALL push rom_rdata into the FIFO at the edge ending the cycle after a rom_en, unless a pc_load or reset intervened (the word is discarded).
REQ-019 SHALL classify the head word as long when (w&16'hFC0F)==16'h9000 (LDS/STS) or (w&16'hFE0C)==16'h940C (JMP/CALL).
REQ-020 SHALL assert instr_valid when count>=1 and the head is short, or when count>=2 and the head is long.
REQ-021 SHALL drive instruction, instr_ext and instr_long to 0 whenever instr_valid=0.
REQ-022 SHALL, on instr_ack=1 with instr_valid=1, pop 1 word (short) or 2 words (long) and add 1 or 2 to program_counter.
REQ-023 SHALL ignore instr_ack when instr_valid=0.
REQ-024 SHALL allow a pop and a push in the same edge, with count updated by the net change.
REQ-025 SHALL, on pc_load=1: empty the FIFO, cancel the in-flight word, and set fpc and program_counter to pc_new.
REQ-026 SHALL give pc_load priority over instr_ack in the same cycle; the ack is dropped.
REQ-027 SHALL have redirect latency: pc_load sampled at edge E0 -> rom_en in cycle E0..E1 -> push at E2 -> instr_valid after E2 (short target).
REQ-028 SHALL wrap fpc and program_counter modulo 2^PC_WIDTH, with no error indication.
REQ-029 SHALL sustain one short instruction per cycle when instr_ack is held high and the queue is primed.

Reset
REQ-030 SHALL, while reset=1: empty the FIFO, clear the in-flight flag, set fpc=0 and program_counter=0, and hold rom_en=0, instr_valid=0 and all data outputs at 0.
REQ-031 SHALL discard a ROM response arriving on the first edge after reset deasserts if its read was issued before reset.
REQ-032 SHALL begin fetching from address 0 in the first cycle after reset deasserts.

Verification
REQ-033 SHALL pass the reset-prime test: release reset with a ROM of NOPs (0x0000) and ack=0 -> rom_addr 0,1,2,3 issued, rom_en drops with count=4, instr_valid=1, program_counter=0.
REQ-034 SHALL pass the streaming test: ack held high over short instructions -> program_counter advances by 1 every cycle after priming, with no bubbles.
REQ-035 SHALL pass the long-instruction test: word0=0x940C and word1=0x0123 at address 5 -> instr_long=1, instr_ext=0x0123, and the ack moves program_counter from 5 to 7.
REQ-036 SHALL pass the long-head-underflow test: DEPTH=2 with a long head and only 1 word queued -> instr_valid=0 until the second word is pushed.
REQ-037 SHALL pass the redirect test: pc_load with pc_new=0x0200 while a read is in flight and ack=1 -> the stale word is dropped, rom_addr=0x0200 is issued next cycle, and instr_valid returns 2 edges later with program_counter=0x0200.
REQ-038 SHALL pass the wrap test: PC_WIDTH=14, pc_new=0x3FFF with short instructions -> after the ack program_counter=0x0000, and fetch continues at address 0.
